// File: rtl/param_pic_core_pkg.sv
// pic_pkg: shared types, defaults and the rotating-priority search used by
// the PIC core.
//   - pic_state_e : two-pulse acknowledge FSM states
//   - prio_res_t  : result of a priority search (found flag, index, rank)
//   - rot_prio()  : first set bit of a request vector, searching from
//                   last_id+1 (rotating) or from 0 (fixed), modulo n
package pic_pkg;

  localparam int DEF_NUM_IRQ = 8;
  localparam int DEF_VEC_W   = 8;
  localparam int MAX_IRQ     = 32;
  localparam int PRIO_IDX_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    VEC   = 2'd3
  } pic_state_e;

  typedef struct packed {
    logic                  found;
    logic [PRIO_IDX_W-1:0] idx;
    logic [PRIO_IDX_W-1:0] rank;  // distance from the start of the search order
  } prio_res_t;

  // Search vec[0..n-1] starting at (rotate ? last_id+1 : 0), wrapping at n.
  // rank is the position in that order, so a lower rank means higher priority.
  function automatic prio_res_t rot_prio(input logic [MAX_IRQ-1:0]    vec,
                                         input logic [PRIO_IDX_W-1:0] last_id,
                                         input logic                  rotate,
                                         input int                    n);
    prio_res_t r;
    int        start;
    int        idx;
    r     = '0;
    start = 0;
    idx   = 0;
    if (rotate) begin
      start = int'(last_id) + 1;
      if (start >= n) begin
        start = 0;
      end else begin
        start = start;
      end
    end else begin
      start = 0;
    end
    for (int k = 0; k < MAX_IRQ; k++) begin
      if (k < n) begin
        idx = start + k;
        if (idx >= n) begin
          idx = idx - n;
        end else begin
          idx = idx;
        end
        if (vec[idx[4:0]] && !r.found) begin
          r.found = 1'b1;
          r.idx   = idx[4:0];
          r.rank  = k[4:0];
        end else begin
          r = r;
        end
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/param_pic_core_if.sv
// param_pic_core_if: CPU-side handshake of the PIC core.
//   master (bus/control front end): drives inta1/inta2 and EOI commands,
//                                   receives int_out and the vector strobe.
//   slave  (param_pic_core)       : the opposite directions.
interface param_pic_core_if #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) ();

  logic             inta1;
  logic             inta2;
  logic             eoi_valid;
  logic             eoi_specific;
  logic [ID_W-1:0]  eoi_id;
  logic             int_out;
  logic [VEC_W-1:0] vec_out;
  logic             vec_valid;
  logic             spurious;

  modport master (
    output inta1, inta2, eoi_valid, eoi_specific, eoi_id,
    input  int_out, vec_out, vec_valid, spurious
  );

  modport slave (
    input  inta1, inta2, eoi_valid, eoi_specific, eoi_id,
    output int_out, vec_out, vec_valid, spurious
  );

endinterface

// File: rtl/param_pic_core_prio_resolver.sv
// pic_prio_resolver: combinational priority search over NUM_IRQ bits.
//   req     in  : candidate vector
//   last_id in  : rotation anchor (search starts just after it)
//   rotate  in  : 1 = rotating order, 0 = fixed order (bit 0 highest)
//   found   out : any bit of req set
//   idx     out : index of the highest-priority set bit
//   rank    out : position of idx in the current order (0 = highest)
module pic_prio_resolver
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int ID_W    = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  input  logic               rotate,
  output logic               found,
  output logic [ID_W-1:0]    idx,
  output logic [ID_W-1:0]    rank
);

  logic [MAX_IRQ-1:0]    req_ext_s;
  logic [PRIO_IDX_W-1:0] last_ext_s;
  prio_res_t             res_s;

  // Widen to the package search width and run the ordered search.
  always_comb begin
    req_ext_s                = '0;
    req_ext_s[NUM_IRQ-1:0]   = req;
    last_ext_s               = '0;
    last_ext_s[ID_W-1:0]     = last_id;
    res_s                    = rot_prio(req_ext_s, last_ext_s, rotate, NUM_IRQ);
    found                    = res_s.found;
    idx                      = res_s.idx[ID_W-1:0];
    rank                     = res_s.rank[ID_W-1:0];
  end

endmodule

// File: rtl/param_pic_core.sv
// param_pic_core: parametrised 8259-style interrupt controller datapath.
//   clk, rst     : single clock, synchronous active-high reset
//   irq_in       : synchronised request lines
//   level_mode   : per channel 1 = level, 0 = rising edge
//   mask         : per channel 1 = masked
//   rotate_en    : 1 = rotating priority, 0 = fixed (channel 0 highest)
//   aeoi         : automatic EOI when the vector is delivered
//   vec_base     : vector base, vec_out = vec_base + id (mod 2^VEC_W)
//   bus          : inta1/inta2, EOI commands, int_out and vector strobe
//   irr, isr     : request and in-service registers
//   last_id      : last channel serviced, anchor of the rotating order
module param_pic_core
  import pic_pkg::*;
#(
  parameter int NUM_IRQ = DEF_NUM_IRQ,
  parameter int ID_W    = $clog2(NUM_IRQ),
  parameter int VEC_W   = DEF_VEC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] level_mode,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic               rotate_en,
  input  logic               aeoi,
  input  logic [VEC_W-1:0]   vec_base,
  param_pic_core_if.slave    bus,
  output logic [NUM_IRQ-1:0] irr,
  output logic [NUM_IRQ-1:0] isr,
  output logic [ID_W-1:0]    last_id
);

  localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_IRQ - 1);

  pic_state_e         state_r, state_n;
  logic [NUM_IRQ-1:0] irq_smp_r, irq_prv_r;
  logic [NUM_IRQ-1:0] irr_r, isr_r;
  logic [NUM_IRQ-1:0] irr_n_s, isr_n_s, isr_set_s, isr_clr_s, edge_s, cand_s;
  logic [ID_W-1:0]    last_id_r, last_id_n_s, gid_r, eoi_idx_s;
  logic [ID_W-1:0]    win_idx_s, win_rank_s, top_idx_s, top_rank_s;
  logic               win_found_s, top_found_s, pend_s;
  logic               spur_r, eoi_hit_s, aeoi_hit_s, grant_s;
  logic               int_out_r, vec_valid_r, spurious_r;
  logic [VEC_W-1:0]   vec_out_r;

  assign cand_s = irr_r & ~mask;

  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_req_res (
    .req     (cand_s),
    .last_id (last_id_r),
    .rotate  (rotate_en),
    .found   (win_found_s),
    .idx     (win_idx_s),
    .rank    (win_rank_s)
  );

  pic_prio_resolver #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
    .req     (isr_r),
    .last_id (last_id_r),
    .rotate  (rotate_en),
    .found   (top_found_s),
    .idx     (top_idx_s),
    .rank    (top_rank_s)
  );

  // A request only counts if it outranks everything already in service;
  // equal rank means the same channel, which must not re-enter.
  assign pend_s  = win_found_s & (~top_found_s | (win_rank_s < top_rank_s));
  assign grant_s = (state_r == ACK1) & ~spur_r;

  // Acknowledge FSM next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (bus.inta1) state_n = ACK1;
        else           state_n = IDLE;
      end
      ACK1:    state_n = WAIT2;
      WAIT2: begin
        if (bus.inta2) state_n = VEC;
        else           state_n = WAIT2;
      end
      VEC:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values of irr, isr and last_id from acks, AEOI and EOI commands.
  always_comb begin
    edge_s      = irq_smp_r & ~irq_prv_r;
    isr_set_s   = '0;
    isr_clr_s   = '0;
    eoi_hit_s   = 1'b0;
    eoi_idx_s   = '0;
    aeoi_hit_s  = 1'b0;
    last_id_n_s = last_id_r;
    irr_n_s     = irr_r;

    if (grant_s) isr_set_s[gid_r] = 1'b1;
    else         isr_set_s        = '0;

    if ((state_r == VEC) && aeoi && !spur_r) aeoi_hit_s = 1'b1;
    else                                     aeoi_hit_s = 1'b0;

    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        // Out-of-range ids and already-clear bits leave everything untouched.
        if ((int'(bus.eoi_id) < NUM_IRQ) && isr_r[bus.eoi_id]) begin
          eoi_hit_s = 1'b1;
          eoi_idx_s = bus.eoi_id;
        end else begin
          eoi_hit_s = 1'b0;
        end
      end else if (top_found_s) begin
        eoi_hit_s = 1'b1;
        eoi_idx_s = top_idx_s;
      end else begin
        eoi_hit_s = 1'b0;
      end
    end else begin
      eoi_hit_s = 1'b0;
    end

    if (eoi_hit_s)  isr_clr_s[eoi_idx_s] = 1'b1;
    else            isr_clr_s            = isr_clr_s;
    if (aeoi_hit_s) isr_clr_s[gid_r]     = 1'b1;
    else            isr_clr_s            = isr_clr_s;

    isr_n_s = (isr_r | isr_set_s) & ~isr_clr_s;

    // An EOI and an AEOI on the same bit resolve to that same index.
    if (rotate_en && eoi_hit_s)       last_id_n_s = eoi_idx_s;
    else if (rotate_en && aeoi_hit_s) last_id_n_s = gid_r;
    else                              last_id_n_s = last_id_r;

    // Level channels follow the sampled line; edge channels hold until
    // granted, and a fresh edge in the grant cycle keeps the bit set.
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (level_mode[i]) begin
        irr_n_s[i] = irq_smp_r[i];
      end else begin
        irr_n_s[i] = edge_s[i] | (irr_r[i] & ~(grant_s & (gid_r == ID_W'(i))));
      end
    end
  end

  // State, request/in-service registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      irq_smp_r   <= '0;
      irq_prv_r   <= '0;
      irr_r       <= '0;
      isr_r       <= '0;
      last_id_r   <= LAST_IDX;
      gid_r       <= LAST_IDX;
      spur_r      <= 1'b0;
      int_out_r   <= 1'b0;
      vec_valid_r <= 1'b0;
      spurious_r  <= 1'b0;
      vec_out_r   <= '0;
    end else begin
      state_r     <= state_n;
      irq_smp_r   <= irq_in;
      irq_prv_r   <= irq_smp_r;
      irr_r       <= irr_n_s;
      isr_r       <= isr_n_s;
      last_id_r   <= last_id_n_s;
      if ((state_r == IDLE) && bus.inta1) begin
        gid_r  <= pend_s ? win_idx_s : LAST_IDX;
        spur_r <= ~pend_s;
      end
      int_out_r   <= (state_n == IDLE) & pend_s;
      vec_valid_r <= (state_n == VEC);
      spurious_r  <= (state_n == VEC) & spur_r;
      if ((state_r == WAIT2) && bus.inta2) begin
        vec_out_r <= vec_base + VEC_W'(gid_r);
      end
    end
  end

  assign bus.int_out   = int_out_r;
  assign bus.vec_out   = vec_out_r;
  assign bus.vec_valid = vec_valid_r;
  assign bus.spurious  = spurious_r;
  assign irr           = irr_r;
  assign isr           = isr_r;
  assign last_id       = last_id_r;

endmodule

// File: tb/tb_param_pic_core.sv
// tb_param_pic_core: directed bench for param_pic_core with an 8-channel
// and a 16-channel instance sharing clock and reset.
module tb_param_pic_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  irq8, lvl8, mask8, base8, irr8, isr8;
  logic        rot8, aeoi8;
  logic [2:0]  last8;
  logic [15:0] irq16, lvl16, mask16, irr16, isr16;
  logic [7:0]  base16;
  logic [3:0]  last16;

  param_pic_core_if #(.NUM_IRQ(8),  .VEC_W(8)) bus8  ();
  param_pic_core_if #(.NUM_IRQ(16), .VEC_W(8)) bus16 ();

  param_pic_core #(.NUM_IRQ(8), .VEC_W(8)) dut8 (
    .clk(clk), .rst(rst), .irq_in(irq8), .level_mode(lvl8), .mask(mask8),
    .rotate_en(rot8), .aeoi(aeoi8), .vec_base(base8), .bus(bus8),
    .irr(irr8), .isr(isr8), .last_id(last8)
  );

  param_pic_core #(.NUM_IRQ(16), .VEC_W(8)) dut16 (
    .clk(clk), .rst(rst), .irq_in(irq16), .level_mode(lvl16), .mask(mask16),
    .rotate_en(1'b0), .aeoi(1'b0), .vec_base(base16), .bus(bus16),
    .irr(irr16), .isr(isr16), .last_id(last16)
  );

  int errors = 0;
  int checks = 0;
  logic       vv, sp;
  logic [7:0] vo;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    irq8 = 8'h00; irq16 = 16'h0000;
    bus8.inta1 = 1'b0;  bus8.inta2 = 1'b0;  bus8.eoi_valid = 1'b0;
    bus8.eoi_specific = 1'b0;  bus8.eoi_id = 3'd0;
    bus16.inta1 = 1'b0; bus16.inta2 = 1'b0; bus16.eoi_valid = 1'b0;
    bus16.eoi_specific = 1'b0; bus16.eoi_id = 4'd0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  // Full inta1/inta2 pair; returns what was on the vector port in VEC.
  task automatic ack(input bit wide, output logic v, output logic [7:0] o, output logic s);
    if (wide) bus16.inta1 = 1'b1; else bus8.inta1 = 1'b1;
    cyc(1);
    bus16.inta1 = 1'b0; bus8.inta1 = 1'b0;
    cyc(1);
    if (wide) bus16.inta2 = 1'b1; else bus8.inta2 = 1'b1;
    cyc(1);
    bus16.inta2 = 1'b0; bus8.inta2 = 1'b0;
    if (wide) begin v = bus16.vec_valid; o = bus16.vec_out; s = bus16.spurious; end
    else      begin v = bus8.vec_valid;  o = bus8.vec_out;  s = bus8.spurious;  end
    cyc(1);
  endtask

  task automatic eoi8(input logic specific, input logic [2:0] id);
    bus8.eoi_valid = 1'b1; bus8.eoi_specific = specific; bus8.eoi_id = id;
    cyc(1);
    bus8.eoi_valid = 1'b0; bus8.eoi_specific = 1'b0;
  endtask

  task automatic test_reset();
    lvl8 = 8'h00; mask8 = 8'h00; rot8 = 1'b0; aeoi8 = 1'b0; base8 = 8'h20;
    lvl16 = 16'h0000; mask16 = 16'h0000; base16 = 8'hF8;
    do_reset();
    checks++; if (irr8 !== 8'h00) begin errors++; $display("FAIL reset_irr: got %h want 00", irr8); end
    checks++; if (isr8 !== 8'h00) begin errors++; $display("FAIL reset_isr: got %h want 00", isr8); end
    checks++; if (bus8.int_out !== 1'b0) begin errors++; $display("FAIL reset_int_out: got %b want 0", bus8.int_out); end
    checks++; if (bus8.vec_valid !== 1'b0 || bus8.spurious !== 1'b0) begin errors++; $display("FAIL reset_strobes: got %b%b want 00", bus8.vec_valid, bus8.spurious); end
    checks++; if (bus8.vec_out !== 8'h00) begin errors++; $display("FAIL reset_vec_out: got %h want 00", bus8.vec_out); end
    checks++; if (last8 !== 3'd7) begin errors++; $display("FAIL reset_last8: got %0d want 7", last8); end
    checks++; if (last16 !== 4'd15) begin errors++; $display("FAIL reset_last16: got %0d want 15", last16); end
  endtask

  task automatic test_fixed_nested();
    do_reset();
    irq8 = 8'h28;
    cyc(1);
    checks++; if (irr8 !== 8'h00) begin errors++; $display("FAIL irr_early: got %h want 00", irr8); end
    cyc(1);
    checks++; if (irr8 !== 8'h28) begin errors++; $display("FAIL irr_latch: got %h want 28", irr8); end
    checks++; if (bus8.int_out !== 1'b0) begin errors++; $display("FAIL int_early: got %b want 0", bus8.int_out); end
    cyc(1);
    checks++; if (bus8.int_out !== 1'b1) begin errors++; $display("FAIL int_rise: got %b want 1", bus8.int_out); end
    bus8.inta1 = 1'b1;
    cyc(1);
    bus8.inta1 = 1'b0;
    checks++; if (bus8.int_out !== 1'b0) begin errors++; $display("FAIL int_ack1: got %b want 0", bus8.int_out); end
    cyc(1);
    checks++; if (isr8 !== 8'h08) begin errors++; $display("FAIL isr_set: got %h want 08", isr8); end
    checks++; if (irr8 !== 8'h20) begin errors++; $display("FAIL irr_clr: got %h want 20", irr8); end
    bus8.inta2 = 1'b1;
    cyc(1);
    bus8.inta2 = 1'b0;
    checks++; if (bus8.vec_valid !== 1'b1 || bus8.vec_out !== 8'h23 || bus8.spurious !== 1'b0) begin
      errors++; $display("FAIL vec3: got v=%b vec=%h sp=%b want v=1 vec=23 sp=0", bus8.vec_valid, bus8.vec_out, bus8.spurious); end
    cyc(1);
    checks++; if (bus8.vec_valid !== 1'b0) begin errors++; $display("FAIL vec_one_cycle: got %b want 0", bus8.vec_valid); end
    cyc(2);
    checks++; if (bus8.int_out !== 1'b0) begin errors++; $display("FAIL int_blocked: got %b want 0", bus8.int_out); end
    eoi8(1'b0, 3'd0);
    checks++; if (isr8 !== 8'h00) begin errors++; $display("FAIL ns_eoi: got %h want 00", isr8); end
    cyc(1);
    checks++; if (bus8.int_out !== 1'b1) begin errors++; $display("FAIL int_after_eoi: got %b want 1", bus8.int_out); end
  endtask

  task automatic test_rotate_aeoi();
    rot8 = 1'b1; aeoi8 = 1'b1; lvl8 = 8'h07;
    do_reset();
    irq8 = 8'h07;
    cyc(3);
    for (int k = 0; k < 3; k++) begin
      ack(1'b0, vv, vo, sp);
      checks++; if (vv !== 1'b1 || vo !== 8'(8'h20 + k)) begin
        errors++; $display("FAIL rot_order%0d: got v=%b vec=%h want v=1 vec=%h", k, vv, vo, 8'(8'h20 + k)); end
      cyc(1);
    end
    checks++; if (last8 !== 3'd2) begin errors++; $display("FAIL rot_last: got %0d want 2", last8); end
    checks++; if (isr8 !== 8'h00) begin errors++; $display("FAIL rot_isr: got %h want 00", isr8); end
    checks++; if (irr8 !== 8'h07) begin errors++; $display("FAIL rot_irr_level: got %h want 07", irr8); end
    rot8 = 1'b0; aeoi8 = 1'b0; lvl8 = 8'h00;
  endtask

  task automatic test_spurious();
    mask8 = 8'hFF;
    do_reset();
    irq8 = 8'h10;
    cyc(3);
    checks++; if (bus8.int_out !== 1'b0) begin errors++; $display("FAIL masked_int: got %b want 0", bus8.int_out); end
    ack(1'b0, vv, vo, sp);
    checks++; if (vv !== 1'b1 || sp !== 1'b1 || vo !== 8'h27) begin
      errors++; $display("FAIL spurious: got v=%b sp=%b vec=%h want v=1 sp=1 vec=27", vv, sp, vo); end
    checks++; if (isr8 !== 8'h00) begin errors++; $display("FAIL spur_isr: got %h want 00", isr8); end
    mask8 = 8'h00;
  endtask

  task automatic test_nesting();
    do_reset();
    irq8 = 8'h40;
    cyc(3);
    ack(1'b0, vv, vo, sp);
    checks++; if (vo !== 8'h26 || isr8 !== 8'h40) begin errors++; $display("FAIL nest6: got vec=%h isr=%h want 26/40", vo, isr8); end
    irq8 = 8'h44;
    cyc(3);
    checks++; if (bus8.int_out !== 1'b1) begin errors++; $display("FAIL nest2_int: got %b want 1", bus8.int_out); end
    ack(1'b0, vv, vo, sp);
    checks++; if (vo !== 8'h22 || isr8 !== 8'h44) begin errors++; $display("FAIL nest2: got vec=%h isr=%h want 22/44", vo, isr8); end
    irq8 = 8'hC4;
    cyc(4);
    checks++; if (irr8 !== 8'h80 || bus8.int_out !== 1'b0) begin
      errors++; $display("FAIL irq7_blocked: got irr=%h int=%b want 80/0", irr8, bus8.int_out); end
    eoi8(1'b1, 3'd2);
    checks++; if (isr8 !== 8'h40) begin errors++; $display("FAIL spec_eoi: got %h want 40", isr8); end
    cyc(2);
    checks++; if (bus8.int_out !== 1'b0) begin errors++; $display("FAIL irq7_under6: got %b want 0", bus8.int_out); end
  endtask

  task automatic test_level_and_reset();
    lvl8 = 8'h10;
    do_reset();
    irq8 = 8'h10;
    cyc(3);
    checks++; if (bus8.int_out !== 1'b1) begin errors++; $display("FAIL lvl_int: got %b want 1", bus8.int_out); end
    irq8 = 8'h00;
    cyc(3);
    checks++; if (bus8.int_out !== 1'b0 || irr8 !== 8'h00) begin
      errors++; $display("FAIL lvl_drop: got int=%b irr=%h want 0/00", bus8.int_out, irr8); end
    irq8 = 8'h10;
    cyc(3);
    bus8.inta1 = 1'b1;
    cyc(1);
    bus8.inta1 = 1'b0;
    cyc(1);
    checks++; if (isr8 !== 8'h10) begin errors++; $display("FAIL wait2_isr: got %h want 10", isr8); end
    rst = 1'b1;
    cyc(1);
    checks++; if (isr8 !== 8'h00 || irr8 !== 8'h00 || bus8.int_out !== 1'b0 || bus8.vec_valid !== 1'b0 ||
                  bus8.spurious !== 1'b0 || bus8.vec_out !== 8'h00 || last8 !== 3'd7) begin
      errors++; $display("FAIL mid_reset: got isr=%h irr=%h int=%b vv=%b sp=%b vec=%h last=%0d want all 0, last 7",
                         isr8, irr8, bus8.int_out, bus8.vec_valid, bus8.spurious, bus8.vec_out, last8); end
    rst = 1'b0;
    bus8.inta2 = 1'b1;
    cyc(1);
    bus8.inta2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus8.vec_valid !== 1'b0) begin errors++; $display("FAIL no_vec_after_reset%0d: got %b want 0", k, bus8.vec_valid); end
      cyc(1);
    end
    lvl8 = 8'h00;
  endtask

  task automatic test_wrap16();
    do_reset();
    irq16 = 16'h1000;
    cyc(3);
    checks++; if (bus16.int_out !== 1'b1) begin errors++; $display("FAIL wrap_int: got %b want 1", bus16.int_out); end
    ack(1'b1, vv, vo, sp);
    checks++; if (vv !== 1'b1 || vo !== 8'h04 || sp !== 1'b0) begin
      errors++; $display("FAIL wrap_vec: got v=%b vec=%h sp=%b want 1/04/0", vv, vo, sp); end
    checks++; if (isr16 !== 16'h1000) begin errors++; $display("FAIL wrap_isr: got %h want 1000", isr16); end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_fixed_nested();
    test_rotate_aeoi();
    test_spurious();
    test_nesting();
    test_level_and_reset();
    test_wrap16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
